// File: rtl/spi_shift_engine.sv
// Full-duplex SPI bit engine: programmable frame length/bit order, all four
// CPOL/CPHA modes, internal SCK divider and a start/busy/done handshake.
module spi_shift_engine #(
  parameter int MAX_WIDTH = 32,
  parameter int DIV_WIDTH = 8,
  parameter int CNT_W     = $clog2(MAX_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [MAX_WIDTH-1:0] tx_data_i,
  input  logic [CNT_W-1:0]     len_i,
  input  logic                 lsb_first_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic                 sdi_i,
  output logic                 sdo_o,
  output logic                 sck_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [MAX_WIDTH-1:0] rx_data_o
);

  // Edge counter must reach 2*MAX_WIDTH, two bits wider than len_i.
  localparam int EC_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, XFER, TAIL} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     len_q;
  logic                 lsb_q;
  logic                 cpha_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] hc;
  logic [EC_W-1:0]      ec;
  logic [MAX_WIDTH-1:0] tx_sh;
  logic [MAX_WIDTH-1:0] rx_sh;
  logic [MAX_WIDTH-1:0] rx_aligned;

  logic            half_end;
  logic [EC_W-1:0] edge_k;
  logic [EC_W-1:0] two_n;
  logic            toggle;
  logic            sample;
  logic            shift_tx;
  logic            start_acc;
  logic            frame_end;

  always_comb begin
    half_end  = (hc == div_q);
    edge_k    = ec + EC_W'(1);
    two_n     = EC_W'({len_q, 1'b0}) + EC_W'(2);
    toggle    = (state == XFER) && half_end;
    // Odd edge numbers are leading edges; CPHA picks which kind samples.
    sample    = toggle && (edge_k[0] ^ cpha_q);
    shift_tx  = toggle && !(edge_k[0] ^ cpha_q) &&
                (cpha_q ? (edge_k >= EC_W'(3)) : (edge_k != two_n));
    start_acc = (state == IDLE) && start_i;
    frame_end = (state == TAIL) && half_end;

    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = XFER;
      XFER:    if (toggle && (edge_k == two_n)) state_nxt = TAIL;
      TAIL:    if (half_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // LSB-first frames were collected from the top down; right-align them.
  assign rx_aligned = lsb_q ? (rx_sh >> (TOP - len_q)) : rx_sh;
  assign sdo_o      = (state == IDLE) ? 1'b0 : (lsb_q ? tx_sh[0] : tx_sh[MAX_WIDTH-1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sck_o     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rx_data_o <= '0;
      hc        <= '0;
      ec        <= '0;
      len_q     <= '0;
      lsb_q     <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      state  <= state_nxt;
      done_o <= frame_end;
      case (state)
        IDLE: begin
          sck_o  <= cpol_i;
          hc     <= '0;
          ec     <= '0;
          busy_o <= start_i;
          if (start_i) begin
            len_q  <= len_i;
            lsb_q  <= lsb_first_i;
            cpha_q <= cpha_i;
            div_q  <= clk_div_i;
          end
        end
        XFER: begin
          if (half_end) begin
            hc    <= '0;
            sck_o <= ~sck_o;
            ec    <= edge_k;
          end else begin
            hc <= hc + DIV_WIDTH'(1);
          end
        end
        TAIL: begin
          if (half_end) begin
            hc        <= '0;
            busy_o    <= 1'b0;
            rx_data_o <= rx_aligned;
          end else begin
            hc <= hc + DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // MSB-first frames are pre-shifted so the first bit sits at the top.
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      tx_sh <= lsb_first_i ? tx_data_i : (tx_data_i << (TOP - len_i));
      rx_sh <= '0;
    end else begin
      if (shift_tx) tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
      if (sample)   rx_sh <= lsb_q ? {sdi_i, rx_sh[MAX_WIDTH-1:1]}
                                   : {rx_sh[MAX_WIDTH-2:0], sdi_i};
    end
  end

endmodule
